synaptic_current_decoder: RTL and testbench
===========================================

# synaptic_current_decoder

Converts a vector of presynaptic spikes into the signed 8-bit input current consumed by a leaky integrate-fire neuron, closing the spike-to-current direction of the neuron interface in the RSNN datapath. Each spike line carries a programmable signed weight. Weighted spikes are summed into a leaky synaptic-current register that decays toward zero every enabled cycle. The register output drives the downstream neuron's `input_current` directly.

## Interface
- `N_INPUTS`, 4 — number of presynaptic spike lines (2..16)
- `DECAY_SHIFT`, 2 — leak divisor exponent (0..7)
- `clk` in 1 — clock, all state on rising edge
- `reset` in 1 — synchronous, active-high; one clock; reset is synchronous and active-high
- `enable` in 1 — advance current dynamics this cycle
- `spike_in` in N_INPUTS — presynaptic spikes, bit i = input i
- `wt_wr_en` in 1 — weight write strobe
- `wt_wr_idx` in clog2(N_INPUTS) — weight index to write
- `wt_wr_data` in 8 — signed weight value
- `current_out` out 8 — signed synaptic current, registered
- `current_active` out 1 — registered, high when current_out ≠ 0

## Operation
- State: weight file `w[0..N_INPUTS-1]` (signed 8b), current register `c` (signed 8b).
- Reset (sampled on edge): all `w` = 0, `c` = 0, `current_out` = 0, `current_active` = 0. Overrides enable and writes in the same cycle.
- Weight write: when `wt_wr_en`, `w[wt_wr_idx]` ← `wt_wr_data` at the edge. Writes are accepted regardless of `enable`. An out-of-range index (≥ N_INPUTS) is ignored.
- Dynamics, when `enable` = 1:
  - `sum` = Σ `w[i]` over i with `spike_in[i]` = 1. Width is 8+clog2(N_INPUTS) bits, signed, with no overflow.
  - `leak` = 0 if c = 0; otherwise `max(1, |c| >> DECAY_SHIFT)`. |c| is computed in 9 bits, so -128 gives 128.
  - `next` = c − sign(c)·leak + sum, computed at full width.
  - `c` ← saturate(next) to [-128, 127].
- `enable` = 0: `c` holds and `spike_in` is ignored.
- Leak always moves `c` strictly toward zero and never crosses zero. With no spikes, `c` reaches 0 in a finite number of cycles.
- Write/spike collision: if `w[i]` is written in the same cycle that `spike_in[i]` is active, the sum uses the old weight. The new weight takes effect from the next cycle.

## Timing
- Latency is 1 cycle: spikes sampled at edge n appear in `current_out` after edge n.
- `current_active` is updated at the same edge as `current_out`.
- No handshake. `spike_in` is a one-cycle-per-event level, sampled each enabled edge. A spike held high for k enabled cycles counts k times.
- A weight write at edge n is visible in the sum from edge n+1.

## Configuration
- `SYN_WEIGHT_READBACK_EN` defined:
  - adds input `wt_rd_idx` (clog2(N_INPUTS) bits) and output `wt_rd_data` (8 bits);
  - `wt_rd_data` = `w[wt_rd_idx]`, combinational;
  - an out-of-range index reads 0.
- Not defined: both ports are absent and there is no readback mux logic.

## Structure
- Shared package `snn_pkg`:
  - `CUR_W` = 8, `CUR_MAX` = 127, `CUR_MIN` = -128;
  - typedef `cur_t` (signed 8b);
  - a saturate function, shared with the neuron.
- One sub-module, `syn_weight_sum`: the weight file plus the masked adder tree (registers `w`, combinational `sum`). The top module holds leak, saturation and `c`.

## Test plan
All scenarios use N_INPUTS = 4 and DECAY_SHIFT = 2.
- Reset: assert `reset` mid-operation with c = 57 → the next cycle gives `current_out` = 0, `current_active` = 0; a subsequent spike on any input gives 0 (weights cleared).
- Single spike and decay: w0 = 20, spike_in = 0001 for one cycle → `current_out` sequence 20, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0; then `current_active` drops.
- Positive saturation: w0..3 = 100, spike_in = 1111 held → 127 on every cycle (127 − 31 + 400 clamps).
- Negative path: w1 = -50, spike on bit 1 once → -50, -38, -29; hold with spike_in = 0010 from c = -128 → stays -128.
- Enable low: c = 40, `enable` = 0 with spike_in = 1111 for 5 cycles → `current_out` stays 40; a weight write during this window still takes effect.
- Collision: w2 = 10, write w2 = 30 with spike_in = 0100 in the same cycle from c = 0 → 10; spike again next cycle → 10 − 2 + 30 = 38. With `SYN_WEIGHT_READBACK_EN`, `wt_rd_idx` = 2 reads 30.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared RSNN definitions: current width/limits, signed current type and the
// saturation helper also used by the neuron.
package snn_pkg;
   localparam int CUR_W   = 8;
   localparam int CUR_MAX = 127;
   localparam int CUR_MIN = -128;

   typedef logic signed [CUR_W-1:0] cur_t;

   function automatic cur_t sat_cur(input logic signed [31:0] v);
      if (v > CUR_MAX) return cur_t'(CUR_MAX);
      if (v < CUR_MIN) return cur_t'(CUR_MIN);
      return cur_t'(v);
   endfunction
endpackage

// File: rtl/syn_weight_sum.sv
// Synaptic weight file plus masked adder tree over the active spike lines.
// Optional combinational weight readback when SYN_WEIGHT_READBACK_EN is defined.
module syn_weight_sum
   import snn_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int SUM_W    = CUR_W + $clog2(N_INPUTS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [N_INPUTS-1:0]         spike_in,
   input  logic                        wt_wr_en,
   input  logic [$clog2(N_INPUTS)-1:0] wt_wr_idx,
   input  logic [CUR_W-1:0]            wt_wr_data,
`ifdef SYN_WEIGHT_READBACK_EN
   input  logic [$clog2(N_INPUTS)-1:0] wt_rd_idx,
   output logic [CUR_W-1:0]            wt_rd_data,
`endif
   output logic signed [SUM_W-1:0]     sum
);
   cur_t w_q [N_INPUTS];
   cur_t w_d [N_INPUTS];
   logic wr_ok;

   assign wr_ok = wt_wr_en && (32'(wt_wr_idx) < N_INPUTS);

   always_comb begin
      w_d = w_q;
      if (wr_ok) w_d[wt_wr_idx] = wt_wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) w_q <= '{default: '0};
      else       w_q <= w_d;
   end

   // Sum reads the registered weights, so a same-cycle write lands next cycle.
   always_comb begin
      sum = '0;
      for (int i = 0; i < N_INPUTS; i++)
         if (spike_in[i]) sum = sum + SUM_W'(w_q[i]);
   end

`ifdef SYN_WEIGHT_READBACK_EN
   assign wt_rd_data = (32'(wt_rd_idx) < N_INPUTS) ? w_q[wt_rd_idx] : '0;
`endif
endmodule

// File: rtl/synaptic_current_decoder.sv
// Spike vector -> leaky, saturated signed 8-bit synaptic current for the LIF neuron.
// Define SYN_WEIGHT_READBACK_EN to add the wt_rd_idx/wt_rd_data readback port.
module synaptic_current_decoder
   import snn_pkg::*;
#(
   parameter int N_INPUTS    = 4,
   parameter int DECAY_SHIFT = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic [N_INPUTS-1:0]         spike_in,
   input  logic                        wt_wr_en,
   input  logic [$clog2(N_INPUTS)-1:0] wt_wr_idx,
   input  logic [CUR_W-1:0]            wt_wr_data,
`ifdef SYN_WEIGHT_READBACK_EN
   input  logic [$clog2(N_INPUTS)-1:0] wt_rd_idx,
   output logic [CUR_W-1:0]            wt_rd_data,
`endif
   output cur_t                        current_out,
   output logic                        current_active
);
   localparam int SUM_W = CUR_W + $clog2(N_INPUTS);
   localparam int NXT_W = SUM_W + 2;

   logic signed [SUM_W-1:0] sum;
   logic [CUR_W:0]          abs_c, shr_c, leak;
   logic signed [NXT_W-1:0] leak_x, nxt;
   cur_t                    c_q, c_d;
   logic                    active_q, active_d;

   syn_weight_sum #(.N_INPUTS(N_INPUTS), .SUM_W(SUM_W)) u_wsum (
      .clk       (clk),
      .reset     (reset),
      .spike_in  (spike_in),
      .wt_wr_en  (wt_wr_en),
      .wt_wr_idx (wt_wr_idx),
      .wt_wr_data(wt_wr_data),
`ifdef SYN_WEIGHT_READBACK_EN
      .wt_rd_idx (wt_rd_idx),
      .wt_rd_data(wt_rd_data),
`endif
      .sum       (sum)
   );

   always_comb begin
      // 9-bit magnitude so -128 maps to 128; leak floor of 1 guarantees decay to 0.
      abs_c  = c_q[CUR_W-1] ? ((CUR_W+1)'(0) - {c_q[CUR_W-1], c_q}) : {1'b0, c_q};
      shr_c  = abs_c >> DECAY_SHIFT;
      leak   = (c_q == '0) ? '0 : ((shr_c == '0) ? (CUR_W+1)'(1) : shr_c);
      leak_x = NXT_W'(leak);
      nxt    = NXT_W'(c_q) + NXT_W'(sum);
      if (c_q[CUR_W-1]) nxt = nxt + leak_x;
      else              nxt = nxt - leak_x;
      c_d = c_q;
      if (enable) c_d = sat_cur(32'(nxt));
      active_d = (c_d != '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         c_q      <= '0;
         active_q <= 1'b0;
      end else begin
         c_q      <= c_d;
         active_q <= active_d;
      end
   end

   assign current_out    = c_q;
   assign current_active = active_q;
endmodule

// File: tb/tb_synaptic_current_decoder.sv
// Directed self-checking bench for synaptic_current_decoder (N_INPUTS=4, DECAY_SHIFT=2).
module tb_synaptic_current_decoder;
   logic              clk = 1'b0;
   logic              reset;
   logic              enable;
   logic [3:0]        spike_in;
   logic              wt_wr_en;
   logic [1:0]        wt_wr_idx;
   logic [7:0]        wt_wr_data;
`ifdef SYN_WEIGHT_READBACK_EN
   logic [1:0]        wt_rd_idx;
   logic [7:0]        wt_rd_data;
`endif
   logic signed [7:0] current_out;
   logic              current_active;

   int checks = 0;
   int errors = 0;

   synaptic_current_decoder #(.N_INPUTS(4), .DECAY_SHIFT(2)) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .spike_in      (spike_in),
      .wt_wr_en      (wt_wr_en),
      .wt_wr_idx     (wt_wr_idx),
      .wt_wr_data    (wt_wr_data),
`ifdef SYN_WEIGHT_READBACK_EN
      .wt_rd_idx     (wt_rd_idx),
      .wt_rd_data    (wt_rd_data),
`endif
      .current_out   (current_out),
      .current_active(current_active)
   );

   always #5 clk = ~clk;

   // Advance one rising edge; outputs are sampled 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic write_w(input logic [1:0] idx, input logic signed [7:0] val);
      wt_wr_en = 1'b1; wt_wr_idx = idx; wt_wr_data = val;
      tick();
      wt_wr_en = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (current_out !== 8'sd0 || current_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_init out=%0d act=%0b expected 0/0", current_out, current_active);
      end
      write_w(2'd0, 8'sd57);
      spike_in = 4'b0001; tick(); spike_in = 4'b0000;
      checks++;
      if (current_out !== 8'sd57 || current_active !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre out=%0d act=%0b expected 57/1", current_out, current_active);
      end
      // Reset must override enable, spikes and a weight write in the same cycle.
      reset = 1'b1; spike_in = 4'b1111;
      wt_wr_en = 1'b1; wt_wr_idx = 2'd1; wt_wr_data = 8'sd9;
      tick();
      reset = 1'b0; wt_wr_en = 1'b0; spike_in = 4'b0000;
      checks++;
      if (current_out !== 8'sd0 || current_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid out=%0d act=%0b expected 0/0", current_out, current_active);
      end
      spike_in = 4'b1111; tick(); spike_in = 4'b0000;
      checks++;
      if (current_out !== 8'sd0 || current_active !== 1'b0) begin
         errors++;
         $display("FAIL reset_wclr out=%0d act=%0b expected 0/0", current_out, current_active);
      end
   endtask

   task automatic test_decay();
      int exp_seq [12] = '{20, 15, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
      do_reset();
      write_w(2'd0, 8'sd20);
      spike_in = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         tick();
         spike_in = 4'b0000;
         checks++;
         if (current_out !== 8'(exp_seq[k]) || current_active !== (exp_seq[k] != 0)) begin
            errors++;
            $display("FAIL decay[%0d] out=%0d act=%0b expected %0d", k, current_out,
                     current_active, exp_seq[k]);
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 4; i++) write_w(2'(i), 8'sd100);
      spike_in = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (current_out !== 8'sd127) begin
            errors++;
            $display("FAIL sat_pos[%0d] out=%0d expected 127", k, current_out);
         end
      end
      spike_in = 4'b0000;
   endtask

   task automatic test_negative();
      int exp_a [3] = '{-50, -38, -29};
      int exp_b [5] = '{-72, -104, -128, -128, -128};
      do_reset();
      write_w(2'd1, -8'sd50);
      spike_in = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         tick();
         spike_in = 4'b0000;
         checks++;
         if (current_out !== 8'(exp_a[k])) begin
            errors++;
            $display("FAIL neg_decay[%0d] out=%0d expected %0d", k, current_out, exp_a[k]);
         end
      end
      spike_in = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         tick();
         checks++;
         if (current_out !== 8'(exp_b[k]) || current_active !== 1'b1) begin
            errors++;
            $display("FAIL neg_sat[%0d] out=%0d act=%0b expected %0d", k, current_out,
                     current_active, exp_b[k]);
         end
      end
      spike_in = 4'b0000;
   endtask

   task automatic test_enable_low();
      do_reset();
      write_w(2'd0, 8'sd40);
      spike_in = 4'b0001; tick();
      enable = 1'b0; spike_in = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) begin
            wt_wr_en = 1'b1; wt_wr_idx = 2'd3; wt_wr_data = 8'sd5;
         end
         tick();
         wt_wr_en = 1'b0;
         checks++;
         if (current_out !== 8'sd40) begin
            errors++;
            $display("FAIL en_hold[%0d] out=%0d expected 40", k, current_out);
         end
      end
      // 40 - 10 + w3(5) shows the write made while disabled landed.
      enable = 1'b1; spike_in = 4'b1000; tick(); spike_in = 4'b0000;
      checks++;
      if (current_out !== 8'sd35) begin
         errors++;
         $display("FAIL en_wr out=%0d expected 35", current_out);
      end
   endtask

   task automatic test_collision();
      do_reset();
      write_w(2'd2, 8'sd10);
      wt_wr_en = 1'b1; wt_wr_idx = 2'd2; wt_wr_data = 8'sd30; spike_in = 4'b0100;
      tick();
      wt_wr_en = 1'b0;
      checks++;
      if (current_out !== 8'sd10) begin
         errors++;
         $display("FAIL coll_old out=%0d expected 10", current_out);
      end
`ifdef SYN_WEIGHT_READBACK_EN
      wt_rd_idx = 2'd2; #1;
      checks++;
      if (wt_rd_data !== 8'd30) begin
         errors++;
         $display("FAIL coll_rd rd=%0d expected 30", wt_rd_data);
      end
`endif
      tick();
      spike_in = 4'b0000;
      checks++;
      if (current_out !== 8'sd38) begin
         errors++;
         $display("FAIL coll_new out=%0d expected 38", current_out);
      end
   endtask

   initial begin
      reset = 1'b1; enable = 1'b1; spike_in = '0;
      wt_wr_en = 1'b0; wt_wr_idx = '0; wt_wr_data = '0;
`ifdef SYN_WEIGHT_READBACK_EN
      wt_rd_idx = '0;
`endif
      tick();
      test_reset();
      test_decay();
      test_saturation();
      test_negative();
      test_enable_low();
      test_collision();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
